// File: rtl/alu_nibble_sequencer_if.sv
// Request/response bundle for alu_nibble_sequencer: a wide operation goes in over
// valid/ready, the wide result and its flags come back over valid/ready.
interface alu_nibble_sequencer_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  logic         in_valid;
  logic         in_ready;
  logic [2:0]   in_op;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_cin;

  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_result;
  logic         out_n;
  logic         out_z;
  logic         out_c;
  logic         out_v;
  logic         out_err;

  modport master (
    output in_valid, in_op, in_a, in_b, in_cin, out_ready,
    input  in_ready, out_valid, out_result, out_n, out_z, out_c, out_v, out_err
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, in_cin, out_ready,
    output in_ready, out_valid, out_result, out_n, out_z, out_c, out_v, out_err
  );
endinterface

// File: rtl/alu_nibble_sequencer.sv
// Drives a 4-bit combinational ALU once per nibble (LSB first) to execute a wide op.
// Optional macro ALU_SAT_EN clamps signed-overflowing ADD/SUB results to the signed extreme.
module alu_nibble_sequencer #(
  parameter int NIBBLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  alu_nibble_sequencer_if.slave bus,
  output logic [3:0]            alu_a,
  output logic [3:0]            alu_b,
  output logic [2:0]            alu_opcode,
  output logic                  alu_cin,
  input  logic [3:0]            alu_y,
  input  logic                  alu_c
);
  // state  | meaning
  // S_IDLE | waiting for a request, in_ready=1
  // S_RUN  | one cycle per nibble, ALU driven from registers
  // S_DONE | result held with out_valid until the consumer accepts

  localparam int W     = 4 * NIBBLES;
  localparam int IDX_W = $clog2(NIBBLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b101;
  localparam logic [2:0] OP_ADD = 3'b110;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [2:0]       op_q, op_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [W-1:0]     acc_q, acc_d;
  logic [3:0]       alu_a_q, alu_a_d;
  logic [3:0]       alu_b_q, alu_b_d;
  logic [2:0]       alu_op_q, alu_op_d;
  logic             alu_cin_q, alu_cin_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [W-1:0]     res_q, res_d;
  logic             n_q, n_d;
  logic             z_q, z_d;
  logic             c_q, c_d;
  logic             v_q, v_d;
  logic             err_q, err_d;

  logic [IDX_W-1:0] idx_nxt;
  logic [W-1:0]     acc_nxt;
  logic [W-1:0]     res_fin;
  logic             c_raw;
  logic             v_raw;

  function automatic logic op_supported(input logic [2:0] op);
    return (op == OP_AND) || (op == OP_OR) || (op == OP_XOR) ||
           (op == OP_SUB) || (op == OP_ADD);
  endfunction

  function automatic logic op_arith(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

  // Result of the nibble in flight folded into the accumulator, plus flags on the full word.
  always_comb begin
    idx_nxt = idx_q + IDX_W'(1);
    acc_nxt = acc_q;
    acc_nxt[{idx_q, 2'b00} +: 4] = alu_y;
    c_raw = op_arith(op_q) & alu_c;
    v_raw = 1'b0;
    if (op_q == OP_ADD)
      v_raw = (a_q[W-1] == b_q[W-1]) && (acc_nxt[W-1] != a_q[W-1]);
    else if (op_q == OP_SUB)
      v_raw = (a_q[W-1] != b_q[W-1]) && (acc_nxt[W-1] != a_q[W-1]);
    res_fin = acc_nxt;
`ifdef ALU_SAT_EN
    // Overflow direction follows A's sign: a positive A can only overflow upwards.
    if (v_raw)
      res_fin = a_q[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_op_d    = alu_op_q;
    alu_cin_d   = alu_cin_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    res_d       = res_q;
    n_d         = n_q;
    z_d         = z_q;
    c_d         = c_q;
    v_d         = v_q;
    err_d       = err_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          op_d       = bus.in_op;
          a_d        = bus.in_a;
          b_d        = bus.in_b;
          acc_d      = '0;
          idx_d      = '0;
          in_ready_d = 1'b0;
          res_d      = '0;
          n_d        = 1'b0;
          z_d        = 1'b0;
          c_d        = 1'b0;
          v_d        = 1'b0;
          err_d      = ~op_supported(bus.in_op);
          if (op_supported(bus.in_op)) begin
            state_d   = S_RUN;
            alu_a_d   = bus.in_a[3:0];
            alu_b_d   = bus.in_b[3:0];
            alu_op_d  = bus.in_op;
            alu_cin_d = op_arith(bus.in_op) & bus.in_cin;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_RUN: begin
        acc_d = acc_nxt;
        if (idx_q == LAST_IDX) begin
          state_d     = S_DONE;
          out_valid_d = 1'b1;
          res_d       = res_fin;
          n_d         = res_fin[W-1];
          z_d         = (res_fin == '0);
          c_d         = c_raw;
          v_d         = v_raw;
          alu_a_d     = '0;
          alu_b_d     = '0;
          alu_op_d    = '0;
          alu_cin_d   = 1'b0;
        end else begin
          idx_d     = idx_nxt;
          alu_a_d   = a_q[{idx_nxt, 2'b00} +: 4];
          alu_b_d   = b_q[{idx_nxt, 2'b00} +: 4];
          alu_cin_d = c_raw;
        end
      end
      S_DONE: begin
        // An unsupported op enters DONE straight from IDLE; out_valid follows one edge later.
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
        end else if (bus.out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
      alu_cin_q   <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      res_q       <= '0;
      n_q         <= 1'b0;
      z_q         <= 1'b0;
      c_q         <= 1'b0;
      v_q         <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
      alu_cin_q   <= alu_cin_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      res_q       <= res_d;
      n_q         <= n_d;
      z_q         <= z_d;
      c_q         <= c_d;
      v_q         <= v_d;
      err_q       <= err_d;
    end
  end

  assign alu_a          = alu_a_q;
  assign alu_b          = alu_b_q;
  assign alu_opcode     = alu_op_q;
  assign alu_cin        = alu_cin_q;
  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_result = res_q;
  assign bus.out_n      = n_q;
  assign bus.out_z      = z_q;
  assign bus.out_c      = c_q;
  assign bus.out_v      = v_q;
  assign bus.out_err    = err_q;
endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// Bench for alu_nibble_sequencer: 4-bit ALU model on the ALU side, wide-arithmetic
// reference model for results, flags, latency and per-nibble carry-in.
module tb_alu_nibble_sequencer;
  localparam int NIBBLES = 4;
  localparam int W       = 4 * NIBBLES;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] alu_a, alu_b, alu_y;
  logic [2:0] alu_opcode;
  logic       alu_cin, alu_c;
  int         tests = 0;
  int         fails = 0;

  alu_nibble_sequencer_if #(.NIBBLES(NIBBLES)) bus_if ();

  alu_nibble_sequencer #(.NIBBLES(NIBBLES)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus_if),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_opcode (alu_opcode),
    .alu_cin    (alu_cin),
    .alu_y      (alu_y),
    .alu_c      (alu_c)
  );

  always #5 clk = ~clk;

  // The 4-bit ALU the sequencer drives; SUB reports borrow on C.
  always_comb begin
    alu_y = 4'h0;
    alu_c = 1'b0;
    case (alu_opcode)
      3'b000: alu_y = alu_a & alu_b;
      3'b001: alu_y = alu_a | alu_b;
      3'b010: alu_y = alu_a ^ alu_b;
      3'b110: {alu_c, alu_y} = {1'b0, alu_a} + {1'b0, alu_b} + {4'b0, alu_cin};
      3'b101: {alu_c, alu_y} = {1'b0, alu_a} - {1'b0, alu_b} - {4'b0, alu_cin};
      default: ;
    endcase
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void ref_model(input logic [2:0] op, input logic [W-1:0] a, b,
                                    input logic cin, output logic [W-1:0] r,
                                    output logic n, z, c, v, err,
                                    output logic [NIBBLES-1:0] cins);
    longint la, lb, lc, sa, sb, t, st, m, smax, smin;
    la   = longint'(a);
    lb   = longint'(b);
    lc   = cin ? 64'sd1 : 64'sd0;
    sa   = la - (a[W-1] ? (longint'(1) << W) : 0);
    sb   = lb - (b[W-1] ? (longint'(1) << W) : 0);
    smax = (longint'(1) << (W - 1)) - 1;
    smin = -(longint'(1) << (W - 1));
    r = '0; n = 0; z = 0; c = 0; v = 0; err = 0; cins = '0; st = 0;
    case (op)
      3'b000: r = a & b;
      3'b001: r = a | b;
      3'b010: r = a ^ b;
      3'b110: begin
        t  = la + lb + lc;
        r  = t[W-1:0];
        c  = t >= (longint'(1) << W);
        st = sa + sb + lc;
        v  = (st > smax) || (st < smin);
        cins[0] = cin;
        for (int i = 1; i < NIBBLES; i++) begin
          m = longint'(1) << (4 * i);
          cins[i] = ((la % m) + (lb % m) + lc) >= m;
        end
      end
      3'b101: begin
        t  = la - lb - lc;
        r  = t[W-1:0];
        c  = t < 0;
        st = sa - sb - lc;
        v  = (st > smax) || (st < smin);
        cins[0] = cin;
        for (int i = 1; i < NIBBLES; i++) begin
          m = longint'(1) << (4 * i);
          cins[i] = ((la % m) - (lb % m) - lc) < 0;
        end
      end
      default: err = 1;
    endcase
`ifdef ALU_SAT_EN
    if (v) r = (st > 0) ? {1'b0, {(W-1){1'b1}}} : {1'b1, {(W-1){1'b0}}};
`endif
    if (!err) begin
      n = r[W-1];
      z = (r == '0);
    end
  endfunction

  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, b, input logic cin,
                        input int hold, input string tag);
    logic [W-1:0]       er, oa, ob;
    logic               en, ez, ec, ev, ee, op_bad, stable;
    logic [NIBBLES-1:0] ecin, ocin;
    int                 lat, guard;
    ref_model(op, a, b, cin, er, en, ez, ec, ev, ee, ecin);
    guard = 0;
    while (!bus_if.in_ready && guard < 20) begin
      @(posedge clk); #1; guard++;
    end
    chk({tag, "/ready_before"}, 64'(bus_if.in_ready), 64'd1);
    bus_if.in_valid = 1'b1;
    bus_if.in_op    = op;
    bus_if.in_a     = a;
    bus_if.in_b     = b;
    bus_if.in_cin   = cin;
    @(posedge clk); #1;
    bus_if.in_valid = 1'b0;
    lat = 0; oa = '0; ob = '0; ocin = '0; op_bad = 1'b0;
    while (!bus_if.out_valid && lat < 4 * NIBBLES + 4) begin
      if (lat < NIBBLES) begin
        oa[lat*4 +: 4] = alu_a;
        ob[lat*4 +: 4] = alu_b;
        ocin[lat]      = alu_cin;
      end
      if (ee ? (alu_opcode != 3'b000) : (alu_opcode != op)) op_bad = 1'b1;
      @(posedge clk); #1; lat++;
    end
    chk({tag, "/latency"}, 64'(lat), ee ? 64'd1 : 64'(NIBBLES));
    chk({tag, "/result"}, 64'(bus_if.out_result), 64'(er));
    chk({tag, "/flags_nzcve"},
        64'({bus_if.out_n, bus_if.out_z, bus_if.out_c, bus_if.out_v, bus_if.out_err}),
        64'({en, ez, ec, ev, ee}));
    chk({tag, "/alu_opcode_seq_bad"}, 64'(op_bad), 64'd0);
    if (ee) begin
      chk({tag, "/alu_not_driven"}, 64'({oa, ob, ocin}), 64'd0);
    end else begin
      chk({tag, "/alu_a_nibbles"}, 64'(oa), 64'(a));
      chk({tag, "/alu_b_nibbles"}, 64'(ob), 64'(b));
      chk({tag, "/alu_cin_seq"}, 64'(ocin), 64'(ecin));
    end
    chk({tag, "/alu_idle_in_done"}, 64'({alu_a, alu_b, alu_opcode, alu_cin}), 64'd0);
    stable = 1'b1;
    for (int k = 0; k < hold; k++) begin
      bus_if.in_valid = 1'b1;
      bus_if.in_op    = 3'b110;
      bus_if.in_a     = W'($urandom);
      @(posedge clk); #1;
      if (bus_if.out_valid !== 1'b1 || bus_if.in_ready !== 1'b0 ||
          bus_if.out_result !== er ||
          {bus_if.out_n, bus_if.out_z, bus_if.out_c, bus_if.out_v, bus_if.out_err} !==
          {en, ez, ec, ev, ee})
        stable = 1'b0;
    end
    bus_if.in_valid = 1'b0;
    if (hold > 0) chk({tag, "/held_stable"}, 64'(stable), 64'd1);
    bus_if.out_ready = 1'b1;
    @(posedge clk); #1;
    bus_if.out_ready = 1'b0;
    chk({tag, "/after_handshake_valid_ready"}, 64'({bus_if.out_valid, bus_if.in_ready}), 64'b01);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic seen;
    rst              = 1'b1;
    bus_if.in_valid  = 1'b0;
    bus_if.in_op     = 3'b000;
    bus_if.in_a      = '0;
    bus_if.in_b      = '0;
    bus_if.in_cin    = 1'b0;
    bus_if.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    chk("reset/in_ready", 64'(bus_if.in_ready), 64'd1);
    chk("reset/out_valid", 64'(bus_if.out_valid), 64'd0);
    chk("reset/out_result", 64'(bus_if.out_result), 64'd0);
    chk("reset/flags", 64'({bus_if.out_n, bus_if.out_z, bus_if.out_c, bus_if.out_v,
                            bus_if.out_err}), 64'd0);
    chk("reset/alu_bus", 64'({alu_a, alu_b, alu_opcode, alu_cin}), 64'd0);

    run_op(3'b110, 16'h1234, 16'h0FCD, 1'b0, 0, "add_basic");
    run_op(3'b110, 16'h7FFF, 16'h0001, 1'b0, 0, "add_ovf");
    run_op(3'b101, 16'h0000, 16'h0001, 1'b0, 0, "sub_borrow");
    run_op(3'b010, 16'hFFFF, 16'hFFFF, 1'b1, 0, "xor_zero");
    run_op(3'b101, 16'h8000, 16'h0001, 1'b0, 0, "sub_neg_ovf");
    run_op(3'b000, 16'hA5F0, 16'h0FF3, 1'b1, 0, "and");
    run_op(3'b001, 16'hA500, 16'h005A, 1'b0, 0, "or");
    run_op(3'b110, 16'hFFFF, 16'h0000, 1'b1, 3, "backpressure");
    run_op(3'b011, 16'h1234, 16'h5678, 1'b1, 0, "err_011");
    run_op(3'b100, 16'hFFFF, 16'hFFFF, 1'b0, 1, "err_100");
    run_op(3'b111, 16'h0001, 16'h0001, 1'b1, 0, "err_111");

    bus_if.in_valid = 1'b1;
    bus_if.in_op    = 3'b110;
    bus_if.in_a     = 16'h0FFF;
    bus_if.in_b     = 16'h0001;
    bus_if.in_cin   = 1'b0;
    @(posedge clk); #1;
    bus_if.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrun_rst/valid_ready", 64'({bus_if.out_valid, bus_if.in_ready}), 64'b01);
    chk("midrun_rst/alu_bus", 64'({alu_a, alu_b, alu_opcode, alu_cin}), 64'd0);
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (bus_if.out_valid) seen = 1'b1;
    end
    chk("midrun_rst/no_valid_pulse", 64'(seen), 64'd0);

    for (int k = 0; k < 40; k++) begin
      logic [2:0] rop;
      rop = 3'($urandom_range(0, 7));
      run_op(rop, W'($urandom), W'($urandom), 1'($urandom_range(0, 1)),
             int'($urandom_range(0, 2)), $sformatf("rand%0d_op%0d", k, rop));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/alu_nibble_sequencer.md
Name: alu_nibble_sequencer

Overview:
- Initiator and controller for the 4-bit combinational ALU.
- Accepts a wide operation over a valid/ready handshake and drives the ALU once per nibble, least significant nibble first, chaining carry/borrow through the ALU's Cin/C.
- Assembles the wide result and flags, and holds them until the consumer accepts.
- Lets the existing 4-bit datapath execute 16-bit (parameterisable) AND/OR/XOR/ADD/SUB.

Parameters:
- NIBBLES, 4, number of 4-bit slices; datapath width W = 4*NIBBLES (≥2).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  request valid.
- in_ready  output  1  sequencer can accept a request.
- in_op  input  3  ALU opcode: 000 AND, 001 OR, 010 XOR, 101 SUB, 110 ADD; others unsupported.
- in_a  input  W  operand A.
- in_b  input  W  operand B.
- in_cin  input  1  initial carry (ADD) or borrow (SUB).
- alu_a  output  4  nibble of A to the ALU.
- alu_b  output  4  nibble of B to the ALU.
- alu_opcode  output  3  opcode to the ALU.
- alu_cin  output  1  Cin to the ALU.
- alu_y  input  4  ALU result nibble.
- alu_c  input  1  ALU carry/borrow out.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_result  output  W  wide result.
- out_n, out_z, out_c, out_v  output  1 each  negative, zero, carry/borrow, signed overflow.
- out_err  output  1  unsupported opcode.

Behaviour:
- Reset:
  - State IDLE; in_ready=1; out_valid=0.
  - out_result, flags and out_err = 0.
  - alu_a/alu_b/alu_opcode/alu_cin = 0.
  - Nibble index = 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, register in_op, in_a, in_b, in_cin.
  - Supported op → RUN with index 0; unsupported op → DONE.
- RUN, one cycle per nibble i (0..NIBBLES-1):
  - alu_a = A[4i+3:4i], alu_b = B[4i+3:4i], alu_opcode = op. All driven from registers only, so no combinational path from in_*.
  - alu_cin for i=0: in_cin for ADD/SUB, 0 for logical ops.
  - alu_cin for i>0: alu_c captured from nibble i-1 for ADD/SUB, 0 for logical ops.
  - At each edge, capture alu_y into result[4i+3:4i] and alu_c into the carry register.
  - After nibble NIBBLES-1 → DONE.
- Latency: out_valid rises exactly NIBBLES edges after the accepting edge for supported ops, and 1 edge after for unsupported ops.
- DONE:
  - out_valid=1.
  - out_result and all flags are stable until out_valid&&out_ready. On that handshake → IDLE and out_valid=0.
  - in_ready=0 in RUN and DONE. It returns to 1 the cycle after the output handshake; there is no same-cycle bypass.
- ALU outputs in IDLE/DONE: alu_opcode=000, alu_a=alu_b=0, alu_cin=0.
- Flags are computed internally on the W-bit values; the ALU's own N/Z/V are not used:
  - out_n = result[W-1].
  - out_z = (result==0).
  - out_c = final-nibble alu_c for ADD/SUB (carry for ADD, borrow for SUB), 0 for logical ops.
  - out_v, ADD: A[W-1]==B[W-1] && result[W-1]!=A[W-1].
  - out_v, SUB: A[W-1]!=B[W-1] && result[W-1]!=A[W-1].
  - out_v = 0 for logical ops.
- Unsupported op (011, 100, 111): out_result=0, out_err=1, all flags 0. The ALU is not driven.
- Requests arriving while in_ready=0 are ignored; no queueing.
- rst in any state, including mid-RUN: next cycle is IDLE with reset values. The partial result is discarded and no out_valid pulse occurs.

Optional Feature:
- Macro: ALU_SAT_EN.
- Defined: ADD/SUB results with out_v=1 clamp to the signed extreme. Positive overflow gives 0x7FF..F; negative overflow gives 0x800..0.
  - out_n and out_z reflect the clamped value.
  - out_v and out_c still report the raw overflow and carry.
- Undefined: results wrap modulo 2^W; no clamp logic is present.

Test Plan:
1. ADD 0x1234 + 0x0FCD, in_cin=0 → out_result=0x2201, C=0, V=0, N=0, Z=0; out_valid 4 edges after accept; alu_cin sequence per nibble 0,1,1,1.
2. ADD 0x7FFF + 0x0001 → 0x8000, V=1, N=1, C=0. With ALU_SAT_EN: 0x7FFF, N=0, V=1.
3. SUB 0x0000 - 0x0001, in_cin=0 → 0xFFFF, C=1 (borrow), N=1, V=0, Z=0.
4. XOR 0xFFFF ^ 0xFFFF → 0x0000, Z=1, C=0, V=0; alu_cin=0 on all 4 nibbles.
5. Backpressure: out_ready=0 for 3 cycles after out_valid → result and flags stable, in_ready=0, a new in_valid is ignored. Releasing out_ready gives out_valid=0 and in_ready=1 on the next cycle.
6. Error and reset cases:
   - in_op=011 → out_valid 1 edge after accept, out_err=1, result 0.
   - rst asserted after 2 RUN cycles → IDLE next cycle, out_valid never asserted, in_ready=1.
